// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_responder_pkg;

  localparam int WS_W = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_DONE   = 2'd2
  } dmem_state_e;

  // Byte-enable bit 3 is the most significant lane (byte offset 0, big-endian).
  localparam logic [3:0] LANE_ALL     = 4'b1111;
  localparam logic [3:0] LANE_HI_HALF = 4'b1100;
  localparam logic [3:0] LANE_LO_HALF = 4'b0011;
  localparam logic [3:0] LANE_BYTE0   = 4'b1000;

  function automatic logic [3:0] byte_lane(input logic [1:0] offset);
    return LANE_BYTE0 >> offset;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_steer.sv
// Store lane steering: byte enables, replicated write word and misalignment
// detection for word, halfword and byte stores.
module dmem_lane_steer
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        sb,
  input  logic        sh,
  input  logic        wr,
  input  logic [31:0] write_data,
  output logic [3:0]  byte_en,
  output logic [31:0] write_word,
  output logic        misalign
);

  // Sub-word data is replicated so each enabled lane already holds the value.
  always_comb begin
    byte_en    = '0;
    write_word = write_data;
    misalign   = 1'b0;
    if (wr) begin
      if (sb) begin
        byte_en    = byte_lane(addr_lo);
        write_word = {4{write_data[7:0]}};
      end else if (sh) begin
        misalign   = addr_lo[0];
        byte_en    = addr_lo[1] ? LANE_LO_HALF : LANE_HI_HALF;
        write_word = {2{write_data[15:0]}};
      end else begin
        misalign = |addr_lo;
        byte_en  = LANE_ALL;
      end
      if (misalign) byte_en = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-stated word array with big-endian lane writes.
// Optional load/store counters are enabled by defining DMEM_PERF_CNT_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_wr,
  input  logic        mem_sb,
  input  logic        mem_sh,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_err,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_array [DEPTH];

  dmem_state_e       state_q, state_d;
  logic [WS_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              sb_q, sb_d;
  logic              sh_q, sh_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [3:0]        byte_en;
  logic [31:0]       write_word;
  logic              misalign;
  logic [ADDR_W-1:0] word_idx;
  logic              commit;
  logic              mem_we;
  logic              unused_addr_bits;

  // High address bits are dropped on purpose so addresses alias.
  assign unused_addr_bits = |mem_addr[31:ADDR_W+2];

  assign word_idx = addr_q[ADDR_W+1:2];
  assign commit   = (state_q == DMEM_ACCESS) && (wait_cnt_q == '0);
  assign mem_we   = commit && wr_q;

  dmem_lane_steer u_lane_steer (
    .addr_lo    (addr_q[1:0]),
    .sb         (sb_q),
    .sh         (sh_q),
    .wr         (wr_q),
    .write_data (wdata_q),
    .byte_en    (byte_en),
    .write_word (write_word),
    .misalign   (misalign)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    sb_d       = sb_q;
    sh_d       = sh_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (mem_req) begin
          addr_d     = mem_addr[ADDR_W+1:0];
          wdata_d    = mem_write_data;
          wr_d       = mem_wr;
          sb_d       = mem_sb;
          sh_d       = mem_sh;
          wait_cnt_d = WS_W'(WAIT_STATES);
          state_d    = DMEM_ACCESS;
        end
      end
      DMEM_ACCESS: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WS_W'(1);
        end else begin
          if (!wr_q) rdata_d = mem_array[word_idx];
          ready_d = 1'b1;
          err_d   = misalign;
          state_d = DMEM_DONE;
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DMEM_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      sb_q       <= 1'b0;
      sh_q       <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      sb_q       <= sb_d;
      sh_q       <= sh_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Array is not reset; a reset during ACCESS drops the commit via state_q.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_array[word_idx][i*8 +: 8] <= write_word[i*8 +: 8];
      end
    end
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = ready_q;
  assign mem_err       = err_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (state_q == DMEM_DONE) begin
      if (wr_q) begin
        if (store_cnt_q != 32'hFFFF_FFFF) store_cnt_d = store_cnt_q + 32'd1;
      end else begin
        if (load_cnt_q != 32'hFFFF_FFFF) load_cnt_d = load_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`else
  assign load_count  = '0;
  assign store_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (0 and 3 wait states),
// directed and random accesses checked against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        wr    [2];
  logic        sb    [2];
  logic        sh    [2];
  logic [31:0] rd    [2];
  logic        rdy   [2];
  logic        err   [2];
  logic [31:0] lcnt  [2];
  logic [31:0] scnt  [2];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_req(req[0]), .mem_addr(addr[0]),
    .mem_write_data(wdata[0]), .mem_wr(wr[0]), .mem_sb(sb[0]), .mem_sh(sh[0]),
    .mem_read_data(rd[0]), .mem_ready(rdy[0]), .mem_err(err[0]),
    .load_count(lcnt[0]), .store_count(scnt[0])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .mem_req(req[1]), .mem_addr(addr[1]),
    .mem_write_data(wdata[1]), .mem_wr(wr[1]), .mem_sb(sb[1]), .mem_sh(sh[1]),
    .mem_read_data(rd[1]), .mem_ready(rdy[1]), .mem_err(err[1]),
    .load_count(lcnt[1]), .store_count(scnt[1])
  );

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ws [2] = '{0, 3};
  logic [31:0] mdl [2][16];
  logic [31:0] last_rd [2];
  int          lc [2];
  int          sc [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_count(input int v);
`ifdef DMEM_PERF_CNT_EN
    return v;
`else
    return (v == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Reference model: plain word array, byte offset 0 is the top byte.
  task automatic model_op(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic b, input logic h,
                          output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    int off;
    int shift;
    logic [31:0] mask;
    idx = (a >> 2) & 15;
    off = a & 3;
    exp_err = 1'b0;
    if (!w) begin
      last_rd[i] = mdl[i][idx];
      lc[i]++;
    end else begin
      sc[i]++;
      if (b) begin
        shift = (3 - off) * 8;
        mask  = 32'hFF << shift;
        mdl[i][idx] = (mdl[i][idx] & ~mask) | ((d & 32'hFF) << shift);
      end else if (h) begin
        if ((off % 2) == 1) exp_err = 1'b1;
        else begin
          shift = (off >= 2) ? 0 : 16;
          mask  = 32'hFFFF << shift;
          mdl[i][idx] = (mdl[i][idx] & ~mask) | ((d & 32'hFFFF) << shift);
        end
      end else if (off != 0) begin
        exp_err = 1'b1;
      end else begin
        mdl[i][idx] = d;
      end
    end
    exp_rd = last_rd[i];
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic apply_stimulus(input int i, input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic b, input logic h);
    exp_t e;
    logic [31:0] erd;
    logic eerr;
    bit got;
    got = 1'b0;
    req[i] = 1'b1; addr[i] = a; wdata[i] = d; wr[i] = w; sb[i] = b; sh[i] = h;
    model_op(i, a, d, w, b, h, erd, eerr);
    e.inst = i; e.rdata = erd; e.err = eerr; e.due = cyc + 2 + ws[i];
    sbq.push_back(e);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (rdy[i] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout inst=%0d: got no ready, expected ready in cycle %0d", i, e.due);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic idle(input int i, input int n);
    req[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wr[i] = 1'b0; sb[i] = 1'b0; sh[i] = 1'b0;
      last_rd[i] = '0; lc[i] = 0; sc[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("%s_ready[%0d]", tag, i), {31'b0, rdy[i]}, 32'd0);
      check_output($sformatf("%s_err[%0d]", tag, i), {31'b0, err[i]}, 32'd0);
      check_output($sformatf("%s_rdata[%0d]", tag, i), rd[i], last_rd[i]);
      check_output($sformatf("%s_load_count[%0d]", tag, i), lcnt[i], exp_count(lc[i]));
      check_output($sformatf("%s_store_count[%0d]", tag, i), scnt[i], exp_count(sc[i]));
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        if (rdy[i] === 1'b1) begin
          if (sbq.size() == 0 || sbq[0].inst != i) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_ready inst=%0d: got ready=1 expected ready=0 (cycle %0d)", i, cyc);
          end else begin
            e = sbq.pop_front();
            check_output($sformatf("rdata[%0d]", i), rd[i], e.rdata);
            check_output($sformatf("err[%0d]", i), {31'b0, err[i]}, {31'b0, e.err});
            check_output($sformatf("ready_cycle[%0d]", i), cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int idx;
    do_reset();
    check_quiet("reset");

    // Zero wait states: word, byte, halfword and misaligned stores.
    apply_stimulus(0, 32'h10, 32'hDEADBEEF, 1, 0, 0);
    apply_stimulus(0, 32'h10, 32'h0, 0, 0, 0);
    apply_stimulus(0, 32'h10, 32'h11223344, 1, 0, 0);
    apply_stimulus(0, 32'h11, 32'h000000AA, 1, 1, 0);
    apply_stimulus(0, 32'h10, 32'h0, 0, 0, 0);
    apply_stimulus(0, 32'h10, 32'h11223344, 1, 0, 0);
    apply_stimulus(0, 32'h12, 32'h0000BEEF, 1, 0, 1);
    apply_stimulus(0, 32'h10, 32'h0, 0, 0, 0);
    apply_stimulus(0, 32'h13, 32'h00005555, 1, 0, 1);
    apply_stimulus(0, 32'h11, 32'hFFFFFFFF, 1, 0, 0);
    apply_stimulus(0, 32'h13, 32'h00000077, 1, 1, 1);
    idle(0, 2);
    apply_stimulus(0, 32'h8000_1012, 32'h0, 0, 0, 0);
    idle(0, 1);

    // Three wait states, back-to-back requests.
    apply_stimulus(1, 32'h20, 32'hCAFEF00D, 1, 0, 0);
    apply_stimulus(1, 32'h20, 32'h0, 0, 0, 0);
    apply_stimulus(1, 32'h22, 32'h00001234, 1, 0, 1);
    apply_stimulus(1, 32'h20, 32'h0, 0, 0, 0);
    apply_stimulus(1, 32'h20, 32'hCAFEF00D, 1, 0, 0);
    idle(1, 2);
    check_quiet("pre_abort");

    // Reset in the middle of a waited store: no write, no ready pulse.
    req[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h12345678;
    wr[1] = 1'b1; sb[1] = 1'b0; sh[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    req[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin last_rd[i] = '0; lc[i] = 0; sc[i] = 0; end
    @(negedge clk);
    check_output("abort_ready", {31'b0, rdy[1]}, 32'd0);
    check_output("abort_rdata", rd[1], 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1, 8);
    apply_stimulus(1, 32'h20, 32'h0, 0, 0, 0);
    idle(1, 1);

    // Random traffic on a 16-word window with random aliasing upper bits.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 16; w++) begin
        a = ($urandom() & 32'hFFFF_F000) | (w << 2);
        apply_stimulus(i, a, $urandom(), 1, 0, 0);
      end
      for (int n = 0; n < 40; n++) begin
        idx = $urandom_range(0, 15);
        a = ($urandom() & 32'hFFFF_F000) | (idx << 2) | $urandom_range(0, 3);
        apply_stimulus(i, a, $urandom(), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
        if ($urandom_range(0, 3) == 0) idle(i, $urandom_range(1, 3));
      end
      idle(i, 2);
    end

    check_quiet("final");
    do_reset();
    check_quiet("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. The pipeline's MEM stage issues address, store data, write enable and sb/sh size strobes; this block services each request.
- Accesses a word array with big-endian byte-lane writes and returns the full aligned word on loads. Sub-word load extraction stays in write-back.
- Adds programmable wait states and a mem_ready completion pulse, which the pipeline uses to hold its pipeline-register enable low.

Parameters:
ADDR_W, 10, word-address bits; the array holds 2**ADDR_W 32-bit words
WAIT_STATES, 0, extra cycles spent in ACCESS before the access commits (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
mem_req  input  1  request valid; requester holds it and all request fields stable until mem_ready
mem_addr  input  32  byte address
mem_write_data  input  32  store data, right-justified for sb/sh
mem_wr  input  1  1 = store, 0 = load
mem_sb  input  1  byte store
mem_sh  input  1  halfword store
mem_read_data  output  32  aligned word from the last completed load
mem_ready  output  1  one-cycle completion pulse
mem_err  output  1  misalignment flag, valid only while mem_ready=1
load_count  output  32  completed loads (optional feature)
store_count  output  32  completed stores (optional feature)

Behaviour:
- FSM states are IDLE, ACCESS and DONE. Reset forces IDLE, mem_ready=0, mem_err=0, mem_read_data=0, wait counter=0 and both counts=0. Array contents are not reset.
- IDLE with mem_req=1: latch addr, data, wr, sb, sh; load the counter with WAIT_STATES; go to ACCESS. IDLE with mem_req=0: stay in IDLE.
- ACCESS with counter!=0: decrement the counter and stay.
- ACCESS with counter==0, on that edge:
  - store: write enabled lanes to word mem_addr[ADDR_W+1:2];
  - load: register that array word into mem_read_data;
  - go to DONE.
- DONE: mem_ready=1 for exactly one cycle, then IDLE. mem_req is ignored in DONE, so the next request is accepted at the earliest in the cycle after DONE.
- Latency: request seen in cycle 0 gives mem_ready in cycle 2+WAIT_STATES.
- Throughput: one access per 3+WAIT_STATES cycles.
- Lanes are big-endian; byte offset 0 is bits [31:24].
  - sb: lane mem_addr[1:0] gets write_data[7:0].
  - sh: half mem_addr[1] gets write_data[15:0]; offset 0 is [31:16].
  - Otherwise all four lanes are written.
  - If sb and sh are both set, sb wins.
- Misalignment:
  - Cases: sh with addr[0]=1, or a word store with addr[1:0]!=0.
  - Result: no array write and mem_err=1 with mem_ready.
- Loads are never misaligned; addr[1:0] is ignored on loads.
- mem_read_data changes only on a completed load and holds across stores and idle cycles.
- Address bits above ADDR_W+1 are ignored, so high addresses alias (wrap-around).
- Reset asserted mid-operation aborts immediately. A request still in ACCESS is dropped with no write and no ready pulse.

Optional Feature:
- DMEM_PERF_CNT_EN defined:
  - load_count increments on each DONE for a load.
  - store_count increments on each DONE for a store, including misaligned stores.
  - Both counters saturate at 32'hFFFFFFFF.
- Macro undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared include holds:
  - state encodings DMEM_IDLE=2'd0, DMEM_ACCESS=2'd1, DMEM_DONE=2'd2;
  - lane-select constants;
  - the WAIT_STATES width (4).
- One sub-module, dmem_lane_steer (combinational): from addr[1:0], sb, sh, wr and write data it produces the 4-bit byte enable, the steered 32-bit write word and the misalign flag.

Test Plan:
- WAIT_STATES=0. Store word 0xDEADBEEF at 0x10, then load 0x10 -> mem_ready in cycle 2 of each request; mem_read_data=0xDEADBEEF; mem_err=0.
- sb of 0x000000AA at 0x11 onto stored 0x11223344, then load 0x10 -> read 0x11AA3344.
- sh of 0x0000BEEF at 0x12 onto 0x11223344 -> reads 0x1122BEEF. sh at 0x13 -> mem_err=1 and the word is unchanged.
- WAIT_STATES=3, with mem_req held -> mem_ready exactly in cycle 5 and deasserted in cycle 6. A request held through DONE is accepted in cycle 6.
- Reset pulsed during ACCESS of a store to 0x20 -> IDLE and mem_ready=0; a later load of 0x20 returns the prior contents.
- DMEM_PERF_CNT_EN defined: 3 loads and 2 stores -> load_count=3, store_count=2. Reset -> both 0.
